cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 42 ++++
 rtl/cdb_arbiter.sv | 120 ++++++++++++
 tb/tb_cdb_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Purpose: handshake and result bus between three producing units (add, mul, ld) and the CDB arbiter.
// Ports: per-unit valid/data/tag in and ready out; broadcast out_data/out_tag/out_sinal toward the CDB register.
// slave = arbiter side, master = producer/consumer side.
interface cdb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
);
  logic              add_valid;
  logic [DATA_W-1:0] add_data;
  logic [TAG_W-1:0]  add_tag;
  logic              add_ready;

  logic              mul_valid;
  logic [DATA_W-1:0] mul_data;
  logic [TAG_W-1:0]  mul_tag;
  logic              mul_ready;

  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic [TAG_W-1:0]  ld_tag;
  logic              ld_ready;

  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_sinal;

  modport slave (
    input  add_valid, add_data, add_tag,
    input  mul_valid, mul_data, mul_tag,
    input  ld_valid,  ld_data,  ld_tag,
    output add_ready, mul_ready, ld_ready,
    output out_data, out_tag, out_sinal
  );

  modport master (
    output add_valid, add_data, add_tag,
    output mul_valid, mul_data, mul_tag,
    output ld_valid,  ld_data,  ld_tag,
    input  add_ready, mul_ready, ld_ready,
    input  out_data, out_tag, out_sinal
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Purpose: round-robin arbiter granting one of three one-entry result buffers onto the CDB per cycle.
// Ports: clock, reset (async, active-high), flush (sync discard), bus (cdb_arbiter_if.slave).
// Latency 1 cycle load-to-broadcast; ready is registered (= buffer empty), so each unit is limited to one result per 2 cycles.
module cdb_arbiter #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);

  // Pointer names the unit searched first; index 0=add, 1=mul, 2=ld.
  typedef enum logic [1:0] {
    PTR_ADD = 2'd0,
    PTR_MUL = 2'd1,
    PTR_LD  = 2'd2
  } unit_e;

  logic [2:0]        full;
  logic [DATA_W-1:0] buf_data [3];
  logic [TAG_W-1:0]  buf_tag  [3];
  unit_e             ptr;
  unit_e             ptr_next;

  logic [2:0]        in_valid;
  logic [DATA_W-1:0] in_data [3];
  logic [TAG_W-1:0]  in_tag  [3];

  logic              gnt_vld;
  logic [1:0]        gnt_idx;
  logic [1:0]        order [3];

  logic [DATA_W-1:0] out_data_q;
  logic [TAG_W-1:0]  out_tag_q;
  logic              out_sinal_q;

  always_comb begin
    in_valid   = {bus.ld_valid, bus.mul_valid, bus.add_valid};
    in_data[0] = bus.add_data;
    in_data[1] = bus.mul_data;
    in_data[2] = bus.ld_data;
    in_tag[0]  = bus.add_tag;
    in_tag[1]  = bus.mul_tag;
    in_tag[2]  = bus.ld_tag;
  end

  // Ready comes straight from the registered full flags.
  assign bus.add_ready = ~full[0];
  assign bus.mul_ready = ~full[1];
  assign bus.ld_ready  = ~full[2];

  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_sinal = out_sinal_q;

  // Round-robin search: scan the rotated order from last to first so the
  // earliest full unit after the pointer is the one left standing.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = 2'd0;
    ptr_next = ptr;
    case (ptr)
      PTR_MUL: order = '{2'd1, 2'd2, 2'd0};
      PTR_LD:  order = '{2'd2, 2'd0, 2'd1};
      default: order = '{2'd0, 2'd1, 2'd2};
    endcase
    for (int k = 2; k >= 0; k--) begin
      if (full[order[k]]) begin
        gnt_vld = 1'b1;
        gnt_idx = order[k];
      end
    end
    if (gnt_vld) begin
      case (gnt_idx)
        2'd0:    ptr_next = PTR_MUL;
        2'd1:    ptr_next = PTR_LD;
        default: ptr_next = PTR_ADD;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full        <= '0;
      ptr         <= PTR_ADD;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_sinal_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        buf_data[i] <= '0;
        buf_tag[i]  <= '0;
      end
    end else if (flush) begin
      // Drop everything pending; pointer and last broadcast value are kept.
      full        <= '0;
      out_sinal_q <= 1'b0;
    end else begin
      out_sinal_q <= gnt_vld;
      if (gnt_vld) begin
        out_data_q    <= buf_data[gnt_idx];
        out_tag_q     <= buf_tag[gnt_idx];
        full[gnt_idx] <= 1'b0;
        ptr           <= ptr_next;
      end
      // A granted unit is full, hence not ready, so the clear above and a
      // load below never target the same flag. Tag 0 means "no producer":
      // the entry is accepted but never marked full.
      for (int i = 0; i < 3; i++) begin
        if (in_valid[i] && !full[i]) begin
          buf_data[i] <= in_data[i];
          buf_tag[i]  <= in_tag[i];
          full[i]     <= (in_tag[i] != '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int DW = 16;
  localparam int TW = 3;

  logic clock = 1'b0;
  logic reset;
  logic flush;

  cdb_arbiter_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

  cdb_arbiter #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Stimulus for the next edge, index 0=add, 1=mul, 2=ld.
  logic          in_v [3];
  logic [DW-1:0] in_d [3];
  logic [TW-1:0] in_t [3];
  logic          in_flush;

  // Reference model: per-unit pending entry, and the unit to be searched first.
  logic          m_full [3];
  logic [DW-1:0] m_dat  [3];
  logic [TW-1:0] m_tag  [3];
  int            m_ptr;
  logic          m_sig;
  logic [DW-1:0] m_od;
  logic [TW-1:0] m_ot;

  int prev_tag;
  int beef_seen;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_full[i] = 1'b0;
      m_dat[i]  = '0;
      m_tag[i]  = '0;
    end
    m_ptr = 0;
    m_sig = 1'b0;
    m_od  = '0;
    m_ot  = '0;
  endtask

  task automatic clr();
    for (int i = 0; i < 3; i++) begin
      in_v[i] = 1'b0;
      in_d[i] = '0;
      in_t[i] = '0;
    end
    in_flush = 1'b0;
  endtask

  // Model of one clock edge, from the rules: flush discards all, otherwise
  // the first pending unit in add->mul->ld order starting at the pointer is
  // broadcast, and empty units take a new offer unless its tag is zero.
  task automatic model_edge();
    int   g;
    logic was_full [3];
    g = -1;
    for (int i = 0; i < 3; i++) was_full[i] = m_full[i];
    for (int k = 0; k < 3; k++) begin
      int u;
      u = (m_ptr + k) % 3;
      if (g < 0 && was_full[u]) g = u;
    end
    if (in_flush) begin
      for (int i = 0; i < 3; i++) m_full[i] = 1'b0;
      m_sig = 1'b0;
    end else begin
      m_sig = (g >= 0);
      if (g >= 0) begin
        m_od      = m_dat[g];
        m_ot      = m_tag[g];
        m_full[g] = 1'b0;
        m_ptr     = (g + 1) % 3;
      end
      for (int i = 0; i < 3; i++) begin
        if (in_v[i] && !was_full[i] && in_t[i] != 0) begin
          m_full[i] = 1'b1;
          m_dat[i]  = in_d[i];
          m_tag[i]  = in_t[i];
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".out_sinal"}, 32'(bus.out_sinal), 32'(m_sig));
    check({ph, ".out_data"},  32'(bus.out_data),  32'(m_od));
    check({ph, ".out_tag"},   32'(bus.out_tag),   32'(m_ot));
    check({ph, ".add_ready"}, 32'(bus.add_ready), 32'(!m_full[0]));
    check({ph, ".mul_ready"}, 32'(bus.mul_ready), 32'(!m_full[1]));
    check({ph, ".ld_ready"},  32'(bus.ld_ready),  32'(!m_full[2]));
    if (bus.out_sinal === 1'b1 && bus.out_data[15:4] === 12'hBEE) beef_seen++;
  endtask

  task automatic drive();
    bus.add_valid = in_v[0]; bus.add_data = in_d[0]; bus.add_tag = in_t[0];
    bus.mul_valid = in_v[1]; bus.mul_data = in_d[1]; bus.mul_tag = in_t[1];
    bus.ld_valid  = in_v[2]; bus.ld_data  = in_d[2]; bus.ld_tag  = in_t[2];
    flush         = in_flush;
  endtask

  task automatic step(input string ph);
    drive();
    @(posedge clock);
    model_edge();
    #1;
    check_all(ph);
  endtask

  // Reset asserted between edges: outputs must settle before any edge.
  task automatic async_reset(input string ph);
    #2;
    reset = 1'b1;
    #1;
    m_reset();
    check_all(ph);
    reset = 1'b0;
  endtask

  initial begin
    clr();
    drive();
    reset = 1'b1;
    m_reset();
    beef_seen = 0;
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    reset = 1'b0;

    // Single uncontended offer.
    in_v[0] = 1'b1; in_d[0] = 16'h1234; in_t[0] = 3'd3;
    step("single.load");
    check("single.add_ready_low", 32'(bus.add_ready), 32'h0);
    clr();
    step("single.bcast");
    check("single.data", 32'(bus.out_data), 32'h1234);
    check("single.tag", 32'(bus.out_tag), 32'h3);
    check("single.sinal", 32'(bus.out_sinal), 32'h1);
    step("single.idle");
    check("single.sinal_off", 32'(bus.out_sinal), 32'h0);

    // Contention from pointer=add: tags broadcast in order 1, 2, 4.
    async_reset("rst_pre_contention");
    in_v[0] = 1'b1; in_d[0] = 16'hA001; in_t[0] = 3'd1;
    in_v[1] = 1'b1; in_d[1] = 16'hA002; in_t[1] = 3'd2;
    in_v[2] = 1'b1; in_d[2] = 16'hA004; in_t[2] = 3'd4;
    step("cont.load");
    clr();
    step("cont.g0");
    check("cont.tag0", 32'(bus.out_tag), 32'h1);
    step("cont.g1");
    check("cont.tag1", 32'(bus.out_tag), 32'h2);
    step("cont.g2");
    check("cont.tag2", 32'(bus.out_tag), 32'h4);
    step("cont.idle");
    check("cont.sinal_off", 32'(bus.out_sinal), 32'h0);

    // Fairness: mul and ld re-offer whenever empty; grants must alternate.
    prev_tag = -1;
    for (int c = 0; c < 10; c++) begin
      clr();
      in_v[1] = !m_full[1]; in_d[1] = 16'h3000 + 16'(c); in_t[1] = 3'd2;
      in_v[2] = !m_full[2]; in_d[2] = 16'h5000 + 16'(c); in_t[2] = 3'd5;
      step("fair");
      if (bus.out_sinal === 1'b1) begin
        if (prev_tag >= 0) check("fair.no_repeat", 32'(bus.out_tag != 3'(prev_tag)), 32'h1);
        prev_tag = int'(bus.out_tag);
      end
    end
    clr();
    repeat (3) step("fair.drain");

    // Tag zero is swallowed.
    in_v[1] = 1'b1; in_d[1] = 16'hBEEF; in_t[1] = 3'd0;
    step("tag0.offer");
    clr();
    step("tag0.w1");
    step("tag0.w2");
    check("tag0.mul_ready", 32'(bus.mul_ready), 32'h1);
    check("tag0.sinal", 32'(bus.out_sinal), 32'h0);

    // Flush with add and ld pending plus a same-edge mul offer.
    in_v[0] = 1'b1; in_d[0] = 16'hBEE1; in_t[0] = 3'd6;
    in_v[2] = 1'b1; in_d[2] = 16'hBEE2; in_t[2] = 3'd7;
    step("flush.load");
    clr();
    in_flush = 1'b1;
    in_v[1] = 1'b1; in_d[1] = 16'hBEE3; in_t[1] = 3'd1;
    step("flush.edge");
    clr();
    repeat (3) step("flush.after");
    check("flush.no_beef", 32'(beef_seen), 32'h0);

    // Async reset while a buffer holds an entry.
    in_v[0] = 1'b1; in_d[0] = 16'h7777; in_t[0] = 3'd6;
    step("arst.load");
    clr();
    async_reset("arst.mid");
    step("arst.after1");
    step("arst.after2");
    check("arst.no_pulse", 32'(bus.out_sinal), 32'h0);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        in_v[i] = 1'($urandom_range(0, 1));
        in_d[i] = 16'($urandom);
        in_t[i] = 3'($urandom_range(0, 7));
      end
      in_flush = ($urandom_range(0, 15) == 0);
      step("rand");
      if (c % 97 == 96) async_reset("rand.rst");
    end
    clr();
    repeat (4) step("rand.drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
